snake_control: RTL and testbench

- Game-state engine for the snake game. Owns the snake segment list, moves it on a periodic tick, steers it from direction keys, grows it when it eats the apple, and detects wall and self collisions.
- Sits directly upstream of the VGA display stage. It answers that stage's pixel query: x_pos/y_pos in, 2-bit cell code out.
- Grid: 40x30 cells of 16x16 px. Cell column = x_pos[9:4], cell row = y_pos[9:4].

---
 rtl/snake_control.sv | 216 +++++++++++++++++++++
 tb/tb_snake_control.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_control.sv
`default_nettype none
// ============================================================================
//  Module   : snake_control
//  Purpose  : Snake game-state engine. Keeps the segment list, moves it on a
//             periodic tick, steers from direction keys, grows on apple, and
//             detects wall/self collisions. Answers per-pixel cell queries
//             from the display stage with a one-clock registered code.
//  Revision : 1.0  initial release
// ============================================================================
module snake_control #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int STEP_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic [1:0] snake,
    output logic       eat,
    output logic       game_over,
    output logic [4:0] length
);

    localparam int CNT_W = $clog2(STEP_DIV);

    // Opposite directions differ only in bit 0 (up/down, left/right)
    localparam logic [1:0] C_DIR_UP    = 2'd0;
    localparam logic [1:0] C_DIR_DOWN  = 2'd1;
    localparam logic [1:0] C_DIR_LEFT  = 2'd2;
    localparam logic [1:0] C_DIR_RIGHT = 2'd3;

    localparam logic [0:0] S_PLAY = 1'b0;
    localparam logic [0:0] S_DEAD = 1'b1;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_HEAD = 2'b01;
    localparam logic [1:0] C_BODY = 2'b10;
    localparam logic [1:0] C_WALL = 2'b11;

    logic [5:0]       r_seg_x [MAX_LEN];
    logic [4:0]       r_seg_y [MAX_LEN];
    logic [4:0]       r_len;
    logic [1:0]       r_dir;
    logic [1:0]       r_pend_dir;
    logic [CNT_W-1:0] r_step_cnt;
    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic             r_eat;
    logic [1:0]       r_snake;

    logic       w_key_valid;
    logic [1:0] w_key_dir;
    logic       w_key_ok;
    logic [1:0] w_move_dir;
    logic       w_tick;
    logic [5:0] w_nh_x;
    logic [4:0] w_nh_y;
    logic       w_hit_apple;
    logic       w_grow;
    logic       w_wall_hit;
    logic       w_self_hit;
    logic       w_collide;
    logic       w_in_range;
    logic [5:0] w_cell_x;
    logic [4:0] w_cell_y;
    logic       w_body_hit;
    logic [1:0] w_query;

    assign w_tick = (r_state == S_PLAY) && (r_step_cnt == CNT_W'(STEP_DIV - 1));

    // Decode keys with up>down>left>right priority
    always_comb begin
        w_key_valid = |key;
        w_key_dir   = C_DIR_RIGHT;
        if (key[3])      w_key_dir = C_DIR_UP;
        else if (key[2]) w_key_dir = C_DIR_DOWN;
        else if (key[1]) w_key_dir = C_DIR_LEFT;
        else             w_key_dir = C_DIR_RIGHT;
    end

    // A key reversing the committed direction is dropped; this cycle's key
    // also steers a move happening on this same cycle
    assign w_key_ok   = w_key_valid && (w_key_dir != (r_dir ^ 2'b01));
    assign w_move_dir = w_key_ok ? w_key_dir : r_pend_dir;

    // Candidate next head position
    always_comb begin
        w_nh_x = r_seg_x[0];
        w_nh_y = r_seg_y[0];
        case (w_move_dir)
            C_DIR_UP:    w_nh_y = r_seg_y[0] - 5'd1;
            C_DIR_DOWN:  w_nh_y = r_seg_y[0] + 5'd1;
            C_DIR_LEFT:  w_nh_x = r_seg_x[0] - 6'd1;
            default:     w_nh_x = r_seg_x[0] + 6'd1;
        endcase
    end

    assign w_hit_apple = (w_nh_x == apple_x) && (w_nh_y == apple_y);
    assign w_grow      = w_hit_apple && (r_len < 5'(MAX_LEN));
    assign w_wall_hit  = (w_nh_x == 6'd0) || (w_nh_x == 6'd39) ||
                         (w_nh_y == 5'd0) || (w_nh_y == 5'd29);

    // Self collision: the tail cell is free unless the snake grows this move
    always_comb begin
        w_self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((r_seg_x[i] == w_nh_x) && (r_seg_y[i] == w_nh_y)) begin
                if (i < int'(r_len) - 1)
                    w_self_hit = 1'b1;
                else if ((i == int'(r_len) - 1) && w_hit_apple)
                    w_self_hit = 1'b1;
            end
        end
    end

    assign w_collide = w_wall_hit | w_self_hit;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_PLAY;
        else        r_state <= w_state_next;
    end

    // FSM next state: DEAD is absorbing until reset
    always_comb begin
        w_state_next = r_state;
        if ((r_state == S_PLAY) && w_tick && w_collide)
            w_state_next = S_DEAD;
    end

    // FSM outputs
    always_comb begin
        game_over = (r_state == S_DEAD);
    end

    // Step counter and direction tracking; both freeze once dead
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_cnt <= '0;
            r_dir      <= C_DIR_RIGHT;
            r_pend_dir <= C_DIR_RIGHT;
        end else if (r_state == S_PLAY) begin
            r_pend_dir <= w_move_dir;
            if (w_tick) begin
                r_step_cnt <= '0;
                r_dir      <= w_move_dir;
            end else begin
                r_step_cnt <= r_step_cnt + CNT_W'(1);
            end
        end
    end

    // Segment shift register and length; untouched on a colliding move
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 6'(20 - i) : 6'd0;
                r_seg_y[i] <= 5'd15;
            end
            r_len <= 5'(INIT_LEN);
        end else if (w_tick && !w_collide) begin
            r_seg_x[0] <= w_nh_x;
            r_seg_y[0] <= w_nh_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
            end
            r_len <= r_len + {4'd0, w_grow};
        end
    end

    // Eat pulse on a successful move onto the apple, saturated or not
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_eat <= 1'b0;
        else        r_eat <= w_tick && !w_collide && w_hit_apple;
    end

    // Pixel query classification against the current (pre-move) segments
    assign w_in_range = (x_pos < 10'd640) && (y_pos < 10'd480);
    assign w_cell_x   = x_pos[9:4];
    assign w_cell_y   = y_pos[8:4];

    always_comb begin
        w_body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(r_len)) && (r_seg_x[i] == w_cell_x) && (r_seg_y[i] == w_cell_y))
                w_body_hit = 1'b1;
        end
        w_query = C_NONE;
        if (w_in_range) begin
            if ((r_seg_x[0] == w_cell_x) && (r_seg_y[0] == w_cell_y))
                w_query = C_HEAD;
            else if (w_body_hit)
                w_query = C_BODY;
            else if ((w_cell_x == 6'd0) || (w_cell_x == 6'd39) ||
                     (w_cell_y == 5'd0) || (w_cell_y == 5'd29))
                w_query = C_WALL;
        end
    end

    // Register the query answer (one clock latency to the display stage)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_snake <= C_NONE;
        else        r_snake <= w_query;
    end

    assign snake  = r_snake;
    assign eat    = r_eat;
    assign length = r_len;

endmodule
`default_nettype wire

// File: tb/tb_snake_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_control
//  Purpose  : Self-checking bench for snake_control. Directed scenarios plus
//             randomized play, compared against a queue-based game model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_snake_control;

    localparam int SD   = 4;
    localparam int MAXL = 16;
    localparam int D_UP = 0;
    localparam int D_DN = 1;
    localparam int D_LF = 2;
    localparam int D_RT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key = 4'd0;
    logic [5:0] apple_x = 6'd5;
    logic [4:0] apple_y = 5'd5;
    logic [9:0] x_pos = 10'd0;
    logic [9:0] y_pos = 10'd0;
    logic [1:0] snake;
    logic       eat;
    logic       game_over;
    logic [4:0] length;

    int total = 0;
    int bad   = 0;
    int n_eat = 0;

    snake_control #(.MAX_LEN(MAXL), .INIT_LEN(3), .STEP_DIV(SD)) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .apple_x   (apple_x),
        .apple_y   (apple_y),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .snake     (snake),
        .eat       (eat),
        .game_over (game_over),
        .length    (length)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct { int x; int y; } cell_t;
    cell_t body[$];
    int m_dir, m_pend, m_cnt;
    bit m_alive;
    int exp_snake, exp_eat;

    function automatic int opposite(input int d);
        case (d)
            D_UP:    return D_DN;
            D_DN:    return D_UP;
            D_LF:    return D_RT;
            default: return D_LF;
        endcase
    endfunction

    task automatic model_reset();
        body.delete();
        for (int i = 0; i < 3; i++) body.push_back('{x: 20 - i, y: 15});
        m_dir = D_RT; m_pend = D_RT; m_cnt = 0; m_alive = 1'b1;
        exp_snake = 0; exp_eat = 0;
    endtask

    function automatic int query_code(input int px, input int py);
        int cx, cy;
        if (px >= 640 || py >= 480) return 0;
        cx = px / 16; cy = py / 16;
        if (cx == body[0].x && cy == body[0].y) return 1;
        for (int i = 1; i < body.size(); i++)
            if (cx == body[i].x && cy == body[i].y) return 2;
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 3;
        return 0;
    endfunction

    // One clock of the game, using the inputs present before the edge
    task automatic model_step();
        int kd, nx, ny, sz;
        bit hit, dead;
        exp_snake = query_code(int'(x_pos), int'(y_pos));
        exp_eat   = 0;
        if (!m_alive) return;
        kd = -1;
        if (key[3])      kd = D_UP;
        else if (key[2]) kd = D_DN;
        else if (key[1]) kd = D_LF;
        else if (key[0]) kd = D_RT;
        if (kd >= 0 && kd != opposite(m_dir)) m_pend = kd;
        if (m_cnt != SD - 1) begin
            m_cnt++;
            return;
        end
        m_cnt = 0;
        m_dir = m_pend;
        nx = body[0].x + ((m_dir == D_RT) ? 1 : 0) - ((m_dir == D_LF) ? 1 : 0);
        ny = body[0].y + ((m_dir == D_DN) ? 1 : 0) - ((m_dir == D_UP) ? 1 : 0);
        hit  = (nx == int'(apple_x)) && (ny == int'(apple_y));
        dead = (nx == 0 || nx == 39 || ny == 0 || ny == 29);
        sz = body.size();
        for (int i = 1; i < sz; i++)
            if (nx == body[i].x && ny == body[i].y && (i < sz - 1 || hit)) dead = 1'b1;
        if (dead) begin
            m_alive = 1'b0;
        end else begin
            body.push_front('{x: nx, y: ny});
            if (!(hit && sz < MAXL)) void'(body.pop_back());
            exp_eat = hit ? 1 : 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int qx, input int qy);
        x_pos = 10'(qx);
        y_pos = 10'(qy);
        @(posedge clk);
        model_step();
        #1;
        if (eat === 1'b1) n_eat++;
        chk("snake", 8'(snake), 8'(exp_snake));
        chk("eat", 8'(eat), 8'(exp_eat));
        chk("game_over", 8'(game_over), 8'(!m_alive));
        chk("length", 8'(length), 8'(body.size()));
    endtask

    // Query a pixel in a cell near the model head
    task automatic cyc_near();
        int cx, cy;
        cx = body[0].x + int'($urandom_range(0, 4)) - 2;
        cy = body[0].y + int'($urandom_range(0, 4)) - 2;
        if (cx < 0) cx = 0;
        if (cy < 0) cy = 0;
        cyc(cx * 16 + int'($urandom_range(0, 15)), cy * 16 + int'($urandom_range(0, 15)));
    endtask

    // Reset pulse started between edges; outputs must clear immediately
    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_game_over", 8'(game_over), 8'd0);
        chk("rst_length", 8'(length), 8'd3);
        chk("rst_eat", 8'(eat), 8'd0);
        chk("rst_snake", 8'(snake), 8'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int r, cx, cy;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_snake", 8'(snake), 8'd0);
        chk("init_eat", 8'(eat), 8'd0);
        chk("init_game_over", 8'(game_over), 8'd0);
        chk("init_length", 8'(length), 8'd3);
        @(negedge clk);
        reset = 1'b1;

        // Initial picture and first moves
        cyc(320, 240); chk("q_head", 8'(snake), 8'd1);
        cyc(304, 240); chk("q_body1", 8'(snake), 8'd2);
        cyc(288, 240); chk("q_body2", 8'(snake), 8'd2);
        cyc(272, 240); chk("q_none", 8'(snake), 8'd0);
        cyc(0, 0);     chk("q_wall", 8'(snake), 8'd3);
        cyc(700, 10);  chk("q_offscreen", 8'(snake), 8'd0);
        cyc(336, 240); chk("moved_head", 8'(snake), 8'd1);
        cyc(288, 240); chk("tail_vacated", 8'(snake), 8'd0);
        key = 4'b0010;
        repeat (4) cyc_near();
        key = 4'b0000;
        cyc(368, 240); chk("reverse_ignored", 8'(snake), 8'd1);

        // Eat on the second move
        apple_x = 6'd22; apple_y = 5'd15;
        do_reset();
        n_eat = 0;
        repeat (8) cyc_near();
        apple_x = 6'd5; apple_y = 5'd5;
        cyc(304, 240); chk("grown_tail", 8'(snake), 8'd2);
        chk("eat_pulses", 8'(n_eat), 8'd1);
        chk("grown_len", 8'(length), 8'd4);

        // Run into the right wall, then stay frozen
        do_reset();
        repeat (80) cyc_near();
        chk("wall_dead", 8'(game_over), 8'd1);
        n_eat = 0;
        repeat (80) cyc_near();
        chk("dead_no_eat", 8'(n_eat), 8'd0);
        cyc(608, 240); chk("dead_head", 8'(snake), 8'd1);

        // Length 5: up, left, down bites the body
        apple_x = 6'd21; apple_y = 5'd15;
        do_reset();
        repeat (4) cyc_near();
        apple_x = 6'd22;
        repeat (4) cyc_near();
        apple_x = 6'd5;
        key = 4'b1000; repeat (4) cyc_near();
        key = 4'b0010; repeat (4) cyc_near();
        key = 4'b0100; repeat (4) cyc_near();
        key = 4'b0000;
        chk("self_hit", 8'(game_over), 8'd1);
        repeat (2) cyc_near();

        // Reset mid-count while dead, then counter restarts from zero
        do_reset();
        cyc(320, 240); chk("rst_head", 8'(snake), 8'd1);
        repeat (3) cyc(336, 240);
        cyc(336, 240); chk("rst_first_move", 8'(snake), 8'd1);

        // Length 4: same turns, tail vacates so no collision
        apple_x = 6'd21; apple_y = 5'd15;
        do_reset();
        repeat (4) cyc_near();
        apple_x = 6'd5;
        repeat (4) cyc_near();
        key = 4'b1000; repeat (4) cyc_near();
        key = 4'b0010; repeat (4) cyc_near();
        key = 4'b0100; repeat (4) cyc_near();
        key = 4'b0000;
        chk("tail_chase_alive", 8'(game_over), 8'd0);
        cyc(336, 240); chk("tail_chase_head", 8'(snake), 8'd1);

        // Randomized play
        for (int round = 0; round < 5; round++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 9) < 7) key = 4'd0;
                else key = 4'($urandom_range(1, 15));
                if ($urandom_range(0, 3) == 0) begin
                    cx = body[0].x; cy = body[0].y;
                    case ($urandom_range(0, 3))
                        0: cx++;
                        1: cx--;
                        2: cy++;
                        default: cy--;
                    endcase
                    if (cx < 1) cx = 1;
                    if (cx > 38) cx = 38;
                    if (cy < 1) cy = 1;
                    if (cy > 28) cy = 28;
                    apple_x = 6'(cx); apple_y = 5'(cy);
                end
                r = int'($urandom_range(0, 9));
                if (r < 6)      cyc_near();
                else if (r < 8) cyc(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
                else            cyc(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
            key = 4'd0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
